// File: rtl/instr_fetch.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the fetch PC and keeps at most one instruction-memory request in
// flight. Decode's branch/jump/jr redirects are applied after exactly one
// delay-slot instruction. A one-entry hold buffer parks a response that
// arrives while decode is stalled.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] redirect_pc;
    logic        redirect_pending;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic        free;
    logic        advance;
    logic        redirect;
    logic        ds_issued;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        issue;
    logic        load_mem;
    logic        load_hold;
    logic        capture;

    // PC-relative branch target: sign-extended word offset, 32-bit wrap.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return base + $unsigned(offset);
    endfunction

    // Region-absolute J/JAL target inside the current 256 MB segment.
    function automatic logic [31:0] jump_abs_target(input logic [3:0]  seg,
                                                    input logic [25:0] index);
        return {seg, index, 2'b00};
    endfunction

    // Redirect decode and effective request address.
    always_comb begin
        pc_plus4  = pc + 32'd4;
        free      = ~instr_valid | ~stall;
        advance   = instr_valid & ~stall;
        redirect  = advance & (jump_reg | jump_target | jump_branch);
        // The delay slot is already requested once fetch_pc has moved past pc+4.
        ds_issued = (fetch_pc != pc_plus4);
        if (jump_reg) begin
            target = jr_pc;
        end else if (jump_target) begin
            target = jump_abs_target(pc_plus4[31:28], instr[25:0]);
        end else begin
            target = branch_target(pc_plus4, instr[15:0]);
        end
        imem_addr = (redirect && ds_issued) ? target : fetch_pc;
    end

    // Fetch FSM next state and per-cycle actions.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        load_mem  = 1'b0;
        load_hold = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // Responses seen here are stale and deliberately ignored.
                if (en) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    if (free) begin
                        load_mem = 1'b1;
                        if (en) begin
                            issue = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (free) begin
                    load_hold = 1'b1;
                    if (en) begin
                        issue     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // No request may escape while reset is held, even with en high.
    assign imem_req = issue & rst_n;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC and deferred-redirect bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc         <= RESET_PC;
            redirect_pending <= 1'b0;
        end else if (redirect) begin
            if (ds_issued) begin
                fetch_pc <= issue ? (target + 32'd4) : target;
            end else if (issue) begin
                // This request is the delay slot; the target comes next.
                fetch_pc <= target;
            end else begin
                redirect_pending <= 1'b1;
            end
        end else if (issue) begin
            if (redirect_pending) begin
                fetch_pc         <= redirect_pc;
                redirect_pending <= 1'b0;
            end else begin
                fetch_pc <= imem_addr + 32'd4;
            end
        end
    end

    // Redirect target parked until the delay slot gets requested.
    always_ff @(posedge clk) begin
        if (redirect && !ds_issued && !issue) begin
            redirect_pc <= target;
        end
    end

    // Address of the outstanding request and the hold buffer contents.
    always_ff @(posedge clk) begin
        if (issue) begin
            req_addr <= imem_addr;
        end
        if (capture) begin
            hold_pc    <= req_addr;
            hold_instr <= imem_rdata;
        end
    end

    // IF/ID register: load, drain to a bubble, or hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= 32'h0000_0000;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (load_mem) begin
            pc          <= req_addr;
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
        end else if (load_hold) begin
            pc          <= hold_pc;
            instr       <= hold_instr;
            instr_valid <= 1'b1;
        end else if (free) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory, a decode model that consumes
// instructions and chooses redirects, and a scoreboard of the architectural
// PC stream (sequential, then delay slot, then target) checked by a monitor.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, en, stall, jump_branch, jump_target, jump_reg;
    logic [31:0] jr_pc, imem_addr, imem_rdata, pc, instr;
    logic        imem_req, imem_valid, instr_valid;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .jump_branch(jump_branch), .jump_target(jump_target), .jump_reg(jump_reg),
        .jr_pc(jr_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .pc(pc), .instr(instr), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program image: explicit words, otherwise an address hash.
    logic [31:0] prog [logic [31:0]];
    typedef struct { int kind; logic [31:0] jr; int stall_n; } plan_t;
    plan_t plan [logic [31:0]];   // kind: 0 none, 1 branch, 2 j, 3 jr

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int cyc = 0;
    int lat_fixed = 1;          // 0 selects random latency 1..3

    initial forever begin
        int d;
        @(negedge clk);
        if (imem_req) begin
            check("single_outstanding", 32'(mq.size()), 32'd0);
            d = cyc + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(3, 1)));
            mq.push_back('{addr: imem_addr, due: d});
        end
    end

    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    // ---------------- decode model / scoreboard producer ----------------
    logic [31:0] exp_q[$];
    bit          ds_pend;
    logic [31:0] ds_tgt;
    bit          fresh;
    int          stall_left;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          consumed  = 0;
    bit          chk_hold  = 0;

    task automatic reset_model();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        ds_pend    = 0;
        fresh      = 1;
        stall_left = 0;
        consumed   = 0;
    endtask

    task automatic drive_decode();
        logic [31:0] p, w, tgt, jr_val;
        shortint     imm;
        int          kind;
        stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
        jr_pc = $urandom;
        if (!rst_n) return;
        if (!instr_valid || exp_q.size() == 0) begin
            if (stall_pct > 0) stall = (int'($urandom_range(99)) < stall_pct);
            {jump_reg, jump_target, jump_branch} = 3'($urandom);
            return;
        end
        p = exp_q[0];
        w = mem_word(p);
        if (fresh) begin
            stall_left = plan.exists(p) ? plan[p].stall_n : 0;
            fresh = 0;
        end
        if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
            stall = 1'b1;
        end
        if (stall) begin
            // Redirect requests during a stall must be ignored.
            {jump_reg, jump_target, jump_branch} = 3'($urandom);
            return;
        end
        fresh = 1;
        if (ds_pend) begin
            exp_q.push_back(ds_tgt);
            ds_pend = 0;
            return;
        end
        kind   = 0;
        jr_val = $urandom;
        if (plan.exists(p)) begin
            kind   = plan[p].kind;
            jr_val = plan[p].jr;
        end else if (redir_pct > 0 && int'($urandom_range(99)) < redir_pct) begin
            kind = int'($urandom_range(3, 1));
        end
        exp_q.push_back(p + 32'd4);
        tgt = 32'h0;
        case (kind)
            1: begin
                jump_branch = 1'b1;
                imm = shortint'(w[15:0]);
                tgt = p + 32'd4 + 32'(int'(imm) * 4);
            end
            2: begin
                jump_target = 1'b1;
                jump_branch = 1'($urandom);
                tgt = ((p + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
            end
            3: begin
                jump_reg = 1'b1;
                {jump_target, jump_branch} = 2'($urandom);
                jr_pc = jr_val;
                tgt = jr_val;
            end
            default: ;
        endcase
        if (kind != 0) begin
            ds_pend = 1;
            ds_tgt  = tgt;
        end
    endtask

    initial begin
        stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0; jr_pc = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            drive_decode();
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (rst_n && instr_valid && !stall) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: pc %h reached decode with no expected entry", pc);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e || instr !== mem_word(e)) begin
                    fails++;
                    $display("FAIL if_id: got pc %h instr %h, expected pc %h instr %h",
                             pc, instr, e, mem_word(e));
                end
                consumed++;
            end
        end
        if (chk_hold && rst_n && instr_valid && stall)
            check("no_req_while_blocked", 32'(imem_req), 32'd0);
    end

    task automatic wait_consumed(input int n, input int budget);
        int c;
        c = 0;
        while (consumed < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("progress", 32'(consumed >= n), 32'd1);
    endtask

    task automatic wait_req_at(input logic [31:0] a, input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(imem_req && imem_addr == a) && c < budget);
        check("req_seen", imem_addr, a);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        prog[32'h0040_0010] = 32'h1000_0004;      // beq $0,$0,+4
        prog[32'h0040_0100] = 32'h0810_0200;      // j 0x00400800
        plan[32'h0040_0010] = '{1, 32'h0, 0};
        plan[32'h0040_0028] = '{0, 32'h0, 3};
        plan[32'h0040_0040] = '{3, 32'h0040_0200, 2};
        reset_model();
        repeat (3) @(posedge clk);
        en = 1'b1;

        // Reset state, with en already high.
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);

        // Back-to-back fetch with 1-cycle memory.
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk_hold = 1;
        @(negedge clk);
        check("req0", imem_addr, RESET_PC);
        check("req0_v", 32'(imem_req), 32'd1);
        check("valid_c0", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("req1", imem_addr, RESET_PC + 32'd4);
        check("valid_c1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("req2", imem_addr, RESET_PC + 32'd8);
        check("valid_c2", 32'(instr_valid), 32'd1);
        check("pc_c2", pc, RESET_PC);
        @(negedge clk);
        check("pc_c3", pc, RESET_PC + 32'd4);

        // Taken beq, stall into hold buffer, jr under stall.
        wait_consumed(20, 300);

        // j with the delay slot not yet requested (3-cycle memory, en dropped).
        @(posedge clk);
        #2 rst_n = 1'b0;
        en = 1'b0;
        chk_hold = 0;
        mq.delete();
        reset_model();
        plan.delete();
        plan[32'h0040_0100] = '{2, 32'h0, 0};
        lat_fixed = 3;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1;
        wait_req_at(32'h0040_0100, 1000);
        @(posedge clk);
        #2 en = 1'b0;
        repeat (8) @(posedge clk);
        #2 en = 1'b1;
        wait_consumed(70, 400);

        // Asynchronous reset with a request in flight, then a stale response.
        wait_req_at(imem_addr, 50);
        @(posedge clk);
        #3 rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_pc", pc, 32'h0);
        check("async_instr", instr, NOP);
        check("async_req", 32'(imem_req), 32'd0);
        reset_model();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("stale_ignored", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #2 en = 1'b1;
        @(negedge clk);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, RESET_PC);

        // Random stalls, redirects and latencies with en held high.
        lat_fixed = 0;
        stall_pct = 30;
        redir_pct = 25;
        chk_hold  = 1;
        wait_consumed(consumed + 300, 4000);

        // Same, with en toggling.
        chk_hold = 0;
        begin
            int target, c;
            target = consumed + 150;
            c = 0;
            while (consumed < target && c < 4000) begin
                @(posedge clk);
                #2 en = (int'($urandom_range(99)) < 75);
                c++;
            end
            en = 1'b1;
            check("progress_en_toggle", 32'(consumed >= target), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
